// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: ROM address/word plus the EXEC-stage instruction link to the MiniAlu datapath.
// oValid qualifies oInstruction; iStall is the datapath's ready (low = ready), so a word is consumed on an edge with oValid=1 and iStall=0.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] oAddress;
    logic [27:0]           iInstruction;
    logic [27:0]           oInstruction;
    logic                  oValid;
    logic                  iStall;
    logic                  iBranchTaken;
    logic                  oFault;

    modport master (
        output oAddress, oInstruction, oValid, oFault,
        input  iInstruction, iStall, iBranchTaken
    );

    modport slave (
        input  oAddress, oInstruction, oValid, oFault,
        output iInstruction, iStall, iBranchTaken
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MiniAlu program sequencer: PC, return-address stack, EXEC-stage redirects, stall hold, fault halt.
// Optional macro NOP_DELAY_EN: a NOP with nonzero immediate N idles the pipe for N cycles.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    parameter int DELAY_WIDTH = 24
) (
    input  logic                          Clock,
    input  logic                          Reset,
    instruction_fetch_unit_if.master      bus,
    output logic [1:0]                    dbg_state_o,
    output logic [$clog2(STACK_DEPTH):0]  dbg_sp_o
);
    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1
`ifdef NOP_DELAY_EN
        , ST_DELAY = 2'd2
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  exec_pc_q, exec_pc_d;
    logic [27:0]            instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   fault_q, fault_d;
    logic [SP_W-1:0]        sp_q, sp_d;
    logic [ADDR_WIDTH-1:0]  stack_q [STACK_DEPTH];
    logic                   push_en;
    logic [IDX_W-1:0]       top_idx;
    logic [3:0]             opcode;
    logic [ADDR_WIDTH-1:0]  target;

`ifdef NOP_DELAY_EN
    logic [DELAY_WIDTH-1:0] dly_q, dly_d;
`else
    logic                   unused_delay_cfg;
    assign unused_delay_cfg = (DELAY_WIDTH > 0);
`endif

    assign opcode  = instr_q[27:24];
    assign target  = {{(ADDR_WIDTH-8){1'b0}}, instr_q[23:16]};
    assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        exec_pc_d = exec_pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        sp_d      = sp_q;
        push_en   = 1'b0;
`ifdef NOP_DELAY_EN
        dly_d     = dly_q;
`endif
        // A stalled datapath freezes everything, including a redirect waiting in EXEC.
        if (!bus.iStall) begin
            case (state_q)
                ST_RUN: begin
                    instr_d   = bus.iInstruction;
                    valid_d   = 1'b1;
                    exec_pc_d = pc_q;
                    pc_d      = pc_q + ADDR_WIDTH'(1);
                    if (valid_q) begin
                        case (opcode)
                            OP_JMP: begin
                                pc_d    = target;
                                valid_d = 1'b0;
                            end
                            OP_BLE: begin
                                if (bus.iBranchTaken) begin
                                    pc_d    = target;
                                    valid_d = 1'b0;
                                end
                            end
                            OP_CALL: begin
                                if (sp_q == SP_W'(STACK_DEPTH)) begin
                                    state_d   = ST_HALT;
                                    fault_d   = 1'b1;
                                    valid_d   = 1'b0;
                                    pc_d      = pc_q;
                                    instr_d   = instr_q;
                                    exec_pc_d = exec_pc_q;
                                end else begin
                                    push_en = 1'b1;
                                    sp_d    = sp_q + SP_W'(1);
                                    pc_d    = target;
                                    valid_d = 1'b0;
                                end
                            end
                            OP_RET: begin
                                if (sp_q == '0) begin
                                    state_d   = ST_HALT;
                                    fault_d   = 1'b1;
                                    valid_d   = 1'b0;
                                    pc_d      = pc_q;
                                    instr_d   = instr_q;
                                    exec_pc_d = exec_pc_q;
                                end else begin
                                    sp_d    = sp_q - SP_W'(1);
                                    pc_d    = stack_q[top_idx];
                                    valid_d = 1'b0;
                                end
                            end
`ifdef NOP_DELAY_EN
                            OP_NOP: begin
                                // The word already addressed is re-fetched once the delay expires.
                                if (instr_q[23:0] != 24'd0) begin
                                    state_d   = ST_DELAY;
                                    dly_d     = DELAY_WIDTH'(instr_q[23:0]);
                                    valid_d   = 1'b0;
                                    pc_d      = pc_q;
                                    instr_d   = instr_q;
                                    exec_pc_d = exec_pc_q;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
`ifdef NOP_DELAY_EN
                ST_DELAY: begin
                    if (dly_q == DELAY_WIDTH'(1)) begin
                        state_d   = ST_RUN;
                        instr_d   = bus.iInstruction;
                        valid_d   = 1'b1;
                        exec_pc_d = pc_q;
                        pc_d      = pc_q + ADDR_WIDTH'(1);
                    end else begin
                        dly_d = dly_q - DELAY_WIDTH'(1);
                    end
                end
`endif
                ST_HALT: valid_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_RUN;
            pc_q      <= '0;
            exec_pc_q <= '0;
            instr_q   <= {OP_NOP, 24'd0};
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            sp_q      <= '0;
`ifdef NOP_DELAY_EN
            dly_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            exec_pc_q <= exec_pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            sp_q      <= sp_d;
`ifdef NOP_DELAY_EN
            dly_q     <= dly_d;
`endif
        end
    end

    // Stack entries need no reset: sp alone decides which entries are live.
    always_ff @(posedge Clock) begin
        if (push_en) begin
            stack_q[sp_q[IDX_W-1:0]] <= exec_pc_q + ADDR_WIDTH'(1);
        end
    end

    assign bus.oAddress     = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oValid       = valid_q;
    assign bus.oFault       = fault_q;
    assign dbg_state_o      = state_q;
    assign dbg_sp_o         = sp_q;
endmodule
